// File: rtl/kill_seq_pkg.sv
// Shared types and default parameters for the kill sequencer.
// Holds the sequencer state enum and a small sizing helper for the hold/vector counter.
package kill_seq_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_VEC = 2'd1,
    RUN      = 2'd2
  } state_e;

  localparam int unsigned DEF_HOLD_CYCLES   = 16;
  localparam logic [15:0] DEF_RESET_HANDLER = 16'hFFFE;
  localparam int unsigned DEF_VEC_TIMEOUT   = 64;

  function automatic int unsigned cnt_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_cnt8.sv
// Saturating 8-bit event counter.
// Once q reaches 8'hFF, further increments are ignored; clr has priority over inc.
module sat_cnt8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != 8'hFF)) begin
      q <= q + 8'd1;
    end
  end

endmodule

// File: rtl/kill_sequencer.sv
// Holds the MCU in reset on any security-monitor kill request, then watches for the
// reset-vector fetch; a missing fetch re-enters the hold and raises a sticky timeout flag.
module kill_sequencer
  import kill_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter logic [15:0] RESET_HANDLER = DEF_RESET_HANDLER,
  parameter int unsigned VEC_TIMEOUT   = DEF_VEC_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [3:0]  kill_req,
  input  logic        cause_clr,
  output logic        core_rst,
  output logic [3:0]  cause,
  output logic [7:0]  kill_cnt,
  output logic        vec_timeout,
  output logic        boot_ok
);

  localparam int unsigned CNT_MAX = cnt_max(HOLD_CYCLES, VEC_TIMEOUT);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(VEC_TIMEOUT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             kill_any;
  logic             episode;
  logic             set_timeout;

  assign kill_any = |kill_req;

  // A kill during HOLD only restarts the hold; it is the same episode, so it is not counted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    episode     = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      HOLD: begin
        if (kill_any) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_VEC;
          cnt_d   = '0;
        end
      end
      WAIT_VEC: begin
        if (kill_any) begin
          state_d = HOLD;
          cnt_d   = '0;
          episode = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == VEC_LAST) begin
          state_d     = HOLD;
          cnt_d       = '0;
          set_timeout = 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (kill_any) begin
          state_d = HOLD;
          episode = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so core_rst rises on the sampling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      core_rst    <= 1'b1;
      boot_ok     <= 1'b0;
      cause       <= '0;
      vec_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_rst    <= (state_d == HOLD);
      boot_ok     <= (state_d == RUN);
      cause       <= (cause_clr ? 4'b0000 : cause) | kill_req;
      vec_timeout <= set_timeout | (vec_timeout & ~cause_clr);
    end
  end

  sat_cnt8 u_episode_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (episode),
    .clr     (1'b0),
    .q       (kill_cnt)
  );

endmodule

// File: tb/tb_kill_sequencer.sv
// Scoreboard bench for kill_sequencer: stimulus queues the expected output events,
// a monitor pops one whenever {core_rst, boot_ok} changes or reset_n is asserted.
module tb_kill_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] pc;
  logic [3:0]  kill_req;
  logic        cause_clr;
  logic        core_rst;
  logic [3:0]  cause;
  logic [7:0]  kill_cnt;
  logic        vec_timeout;
  logic        boot_ok;

  typedef struct {
    logic       core_rst;
    logic       boot_ok;
    logic [3:0] cause;
    logic [7:0] kill_cnt;
    logic       vec_timeout;
    int         len;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ev_num = 0;
  logic [1:0] prev_out = 2'b10;
  int         run_len = 0;

  kill_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc          (pc),
    .kill_req    (kill_req),
    .cause_clr   (cause_clr),
    .core_rst    (core_rst),
    .cause       (cause),
    .kill_cnt    (kill_cnt),
    .vec_timeout (vec_timeout),
    .boot_ok     (boot_ok)
  );

  always #5 clk = ~clk;

  task automatic expect_ev(input logic cr, input logic bo, input logic [3:0] c,
                           input logic [7:0] k, input logic vt, input int len);
    exp_t e;
    e.core_rst    = cr;
    e.boot_ok     = bo;
    e.cause       = c;
    e.kill_cnt    = k;
    e.vec_timeout = vt;
    e.len         = len;
    exp_q.push_back(e);
  endtask

  task automatic check_field(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s event %0d: got %0h, expected %0h", name, ev_num, got, want);
    end
  endtask

  // len < 0 marks a phase whose length depends only on stimulus pacing.
  task automatic checkOutput(input int len);
    exp_t e;
    ev_num++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event event %0d: got core_rst=%0b boot_ok=%0b, expected no event",
               ev_num, core_rst, boot_ok);
    end else begin
      e = exp_q.pop_front();
      check_field("core_rst", 32'(core_rst), 32'(e.core_rst));
      check_field("boot_ok", 32'(boot_ok), 32'(e.boot_ok));
      check_field("cause", 32'(cause), 32'(e.cause));
      check_field("kill_cnt", 32'(kill_cnt), 32'(e.kill_cnt));
      check_field("vec_timeout", 32'(vec_timeout), 32'(e.vec_timeout));
      if (e.len >= 0) check_field("phase_len", 32'(len), 32'(e.len));
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      run_len  = 0;
      prev_out = 2'b10;
    end else if ({core_rst, boot_ok} !== prev_out) begin
      checkOutput(run_len);
      prev_out = {core_rst, boot_ok};
      run_len  = 1;
    end else begin
      run_len++;
    end
  end

  always @(negedge reset_n) begin
    #1;
    checkOutput(-1);
  end

  task automatic applyStimulus(input logic [3:0] kill, input logic clr);
    kill_req  = kill;
    cause_clr = clr;
    @(posedge clk);
    #1;
    kill_req  = 4'b0000;
    cause_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    pc        = 16'h0000;
    kill_req  = 4'b0000;
    cause_clr = 1'b0;

    expect_ev(1'b1, 1'b0, 4'b0000, 8'd0, 1'b0, -1);
    #2 reset_n = 1'b0;
    idle(3);

    // Power-on hold, then boot on the first vector fetch.
    expect_ev(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 16);
    expect_ev(1'b0, 1'b1, 4'b0000, 8'd0, 1'b0, 1);
    reset_n = 1'b1;
    idle(2);
    pc = 16'hFFFE;
    idle(18);

    // Kill in RUN; vector fetched 6 cycles after release.
    pc = 16'h0000;
    expect_ev(1'b1, 1'b0, 4'b0010, 8'd1, 1'b0, -1);
    expect_ev(1'b0, 1'b0, 4'b0010, 8'd1, 1'b0, 16);
    expect_ev(1'b0, 1'b1, 4'b0010, 8'd1, 1'b0, 6);
    applyStimulus(4'b0010, 1'b0);
    idle(21);
    pc = 16'hFFFE;
    idle(3);

    // Hold extended in its 10th cycle, then vector timeout, then recovery.
    pc = 16'h0000;
    expect_ev(1'b1, 1'b0, 4'b0010, 8'd2, 1'b0, -1);
    expect_ev(1'b0, 1'b0, 4'b0110, 8'd2, 1'b0, 26);
    expect_ev(1'b1, 1'b0, 4'b0110, 8'd2, 1'b1, 64);
    expect_ev(1'b0, 1'b0, 4'b0110, 8'd2, 1'b1, 16);
    expect_ev(1'b0, 1'b1, 4'b0110, 8'd2, 1'b1, 1);
    applyStimulus(4'b0010, 1'b0);
    idle(9);
    applyStimulus(4'b0100, 1'b0);
    idle(90);
    pc = 16'hFFFE;
    idle(10);

    // 300 episodes, two request bits each, saturating the counter.
    for (int i = 1; i <= 300; i++) begin
      k = (2 + i > 255) ? 255 : 2 + i;
      expect_ev(1'b1, 1'b0, 4'b0111, 8'(k), 1'b1, -1);
      expect_ev(1'b0, 1'b0, 4'b0111, 8'(k), 1'b1, 16);
      expect_ev(1'b0, 1'b1, 4'b0111, 8'(k), 1'b1, 1);
      applyStimulus(4'b0101, 1'b0);
      idle(17);
    end

    // Clear coinciding with a new kill: new bits win, timeout flag drops.
    expect_ev(1'b1, 1'b0, 4'b1000, 8'hFF, 1'b0, -1);
    applyStimulus(4'b1000, 1'b1);
    idle(7);

    // Async reset while the hold counter sits at 7.
    expect_ev(1'b1, 1'b0, 4'b0000, 8'd0, 1'b0, -1);
    reset_n = 1'b0;
    idle(2);
    expect_ev(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 16);
    expect_ev(1'b0, 1'b1, 4'b0000, 8'd0, 1'b0, 1);
    reset_n = 1'b1;
    idle(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events: got %0d still queued, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kill_sequencer.md
KILL_SEQUENCER -- requirements
Module: kill_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: the number of cycles core_rst is held high per reset episode.
REQ-002 Parameter RESET_HANDLER, default 16'hFFFE: the reset-vector fetch address that marks a successful reboot.
REQ-003 Parameter VEC_TIMEOUT, default 64: the maximum number of cycles to wait for the RESET_HANDLER fetch after release.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
REQ-005 The remaining ports SHALL be:
- pc  in  16  current MCU program counter.
- kill_req  in  4  one bit per security monitor; level-high requests reset.
- cause_clr  in  1  single-cycle clear of the cause register.
- core_rst  out  1  active-high MCU reset; registered.
- cause  out  4  sticky OR of the kill_req bits since the last clear.
- kill_cnt  out  8  saturating count of reset episodes.
- vec_timeout  out  1  sticky flag; set when the reset vector is not fetched within VEC_TIMEOUT.
- boot_ok  out  1  high while in RUN.

Function
REQ-010 The FSM states SHALL be HOLD, WAIT_VEC and RUN, with a single counter cnt sized for max(HOLD_CYCLES, VEC_TIMEOUT).
REQ-011 In HOLD, core_rst SHALL be 1 and cnt SHALL increment; at cnt==HOLD_CYCLES-1 the FSM SHALL go to WAIT_VEC with cnt cleared.
REQ-012 In HOLD, any kill_req bit SHALL reset cnt to 0 (extending the hold), SHALL OR into cause, and SHALL NOT increment kill_cnt.
REQ-013 In WAIT_VEC, core_rst SHALL be 0 and cnt SHALL increment:
- If pc==RESET_HANDLER, the FSM SHALL go to RUN.
- Else at cnt==VEC_TIMEOUT-1, the FSM SHALL go to HOLD and set vec_timeout.
REQ-014 In WAIT_VEC, any kill_req bit SHALL take priority over the pc match and the timeout: the FSM goes to HOLD, cause ORs in kill_req, and kill_cnt increments.
REQ-015 In RUN, core_rst SHALL be 0 and boot_ok SHALL be 1. Any kill_req bit SHALL cause a transition to HOLD, OR kill_req into cause, and increment kill_cnt.
REQ-016 Latency: kill_req sampled high at edge N SHALL give core_rst==1 and boot_ok==0 immediately after edge N, with no combinational path from kill_req to core_rst.
REQ-017 core_rst SHALL fall on the edge that enters WAIT_VEC, which is exactly HOLD_CYCLES cycles after the last cnt restart.
REQ-018 kill_cnt SHALL saturate at 8'hFF.
REQ-019 cause_clr SHALL clear cause and vec_timeout. If it coincides with kill_req, cause SHALL load kill_req (new bits win).
REQ-020 A timeout-induced return to HOLD SHALL NOT increment kill_cnt.
REQ-021 Multiple kill_req bits in the same cycle SHALL count as one episode.

Reset
REQ-030 While reset_n==0, the block SHALL asynchronously set: state=HOLD, cnt=0, core_rst=1, cause=0, kill_cnt=0, vec_timeout=0, boot_ok=0.
REQ-031 After reset_n rises, the power-on hold SHALL follow REQ-011 without counting an episode.
REQ-032 reset_n asserted mid-episode SHALL abort the episode and restart from the reset values.

Structure
REQ-040 The package kill_seq_pkg SHALL hold the state enum and the default values of HOLD_CYCLES, RESET_HANDLER and VEC_TIMEOUT.
REQ-041 The saturating 8-bit episode counter SHALL be a sub-module, sat_cnt8 (inc, clr, q).
REQ-042 The FSM, cnt and the output registers SHALL stay in kill_sequencer.

Verification
REQ-050 Power-on: release reset_n, then present pc=16'hFFFE two cycles after release -> core_rst high for 16 cycles, then low; boot_ok=1; kill_cnt=0; cause=0.
REQ-051 Kill in RUN: kill_req=4'b0010 for 1 cycle -> core_rst=1 next cycle, held for 16 cycles; cause=4'b0010; kill_cnt=1; boot_ok=0 until the next pc=16'hFFFE.
REQ-052 Extension: kill_req=4'b0100 at hold cycle 10 -> hold lasts 10+16 cycles in total; cause=4'b0110; kill_cnt unchanged.
REQ-053 Vector timeout: after release, pc never equals 16'hFFFE -> core_rst re-asserts 64 cycles later; vec_timeout=1; kill_cnt unchanged.
REQ-054 Saturation and clear: 300 kill episodes -> kill_cnt=8'hFF. Then cause_clr together with kill_req=4'b1000 -> cause=4'b1000 and vec_timeout=0.
REQ-055 Async reset during HOLD, at cnt=7 -> outputs immediately return to their reset values, and a fresh 16-cycle hold follows release.
